fifo_drain_unpack: RTL and testbench

//  Read-side drain for the block-RAM FIFO primitive. Single clock (FIFO rd_clk domain).

---
 rtl/fifo_drain_unpack_if.sv | 29 ++
 rtl/fifo_drain_unpack.sv | 129 ++++++++++++
 tb/tb_fifo_drain_unpack.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_drain_unpack_if.sv
// Lane stream from the FIFO drain to its consumer (UART TX, SPI, DMA).
// Latency: none; this is a signal bundle only.
// Backpressure: m_ready from the slave stalls the master on the current lane.
// Ports: m_data (LW), m_valid, m_first, m_last driven by master; m_ready by slave.
interface fifo_drain_unpack_if #(
    parameter int LW = 9
);
    logic [LW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_first;
    logic          m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_first,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_first,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/fifo_drain_unpack.sv
// Drains a non-FWFT FIFO into a small skid buffer and emits each word as LANES lanes, LSB lane first.
// Latency: RD_LAT+1 cycles from fifo_empty falling to the first m_valid; 1 lane/cycle sustained.
// Backpressure: m_ready low holds the current lane; pops stop once skid occupancy plus in-flight reads fill RD_LAT+1 entries.
// Ports: clk, rstn (async active-low), flush (sync drop), FIFO side fifo_empty/fifo_dout/fifo_rderr/fifo_rd_en,
//        stream side via fifo_drain_unpack_if.master m, error status err_sticky/err_count.
// Option: define FIFO_DRAIN_ERR_EN to count fifo_rderr cycles; without it the error outputs are tied to 0.
module fifo_drain_unpack #(
    parameter int WIDTH  = 36,
    parameter int LANES  = 4,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                flush,
    input  logic                fifo_empty,
    input  logic [WIDTH-1:0]    fifo_dout,
    input  logic                fifo_rderr,
    output logic                fifo_rd_en,
    fifo_drain_unpack_if.master m,
    output logic                err_sticky,
    output logic [7:0]          err_count
);
    localparam int LW   = WIDTH / LANES;
    localparam int SKID = RD_LAT + 1;
    localparam int PW   = (SKID > 2) ? 2 : 1;
    localparam int LNW  = (LANES > 1) ? $clog2(LANES) : 1;

    logic [WIDTH-1:0]  skid_mem [SKID];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [1:0]        occ;
    logic [RD_LAT-1:0] pipe;      // one valid bit per outstanding read, oldest at the top
    logic [LNW-1:0]    lane;
    logic [1:0]        inflight;
    logic [2:0]        committed;
    logic              capture;
    logic              valid;
    logic              xfer;
    logic              last_lane;
    logic              head_done;
    logic [WIDTH-1:0]  head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SKID - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + 2'(pipe[i]);
        end
    end

    assign capture   = pipe[RD_LAT-1];
    assign valid     = (occ != 2'd0);
    assign last_lane = (lane == LNW'(LANES - 1));
    assign xfer      = valid & m.m_ready;
    assign head_done = xfer & last_lane;

    // The entry retiring this cycle is credited back immediately; without that
    // credit a full pipe would leave one bubble per RD_LAT+1 words at LANES=1.
    // Worst case stays at SKID entries, so the buffer cannot overflow.
    assign committed  = 3'(occ) + 3'(inflight) - 3'(head_done);
    assign fifo_rd_en = rstn & ~flush & ~fifo_empty & (committed < 3'(SKID));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            pipe   <= '0;
            lane   <= '0;
        end else if (flush) begin
            // Clearing pipe discards data from reads already issued.
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            pipe   <= '0;
            lane   <= '0;
        end else begin
            pipe <= (pipe << 1) | RD_LAT'(fifo_rd_en);
            if (capture) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (head_done) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            occ <= occ + 2'(capture) - 2'(head_done);
            if (xfer) begin
                lane <= last_lane ? '0 : lane + LNW'(1);
            end
        end
    end

    // Data storage needs no reset: nothing reads an entry until occ covers it.
    always_ff @(posedge clk) begin
        if (capture) begin
            skid_mem[wr_ptr] <= fifo_dout;
        end
    end

    assign head      = skid_mem[rd_ptr];
    assign m.m_valid = valid;
    assign m.m_data  = valid ? head[lane*LW +: LW] : '0;
    assign m.m_first = (lane == '0);
    assign m.m_last  = last_lane;

`ifdef FIFO_DRAIN_ERR_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else if (flush) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else if (fifo_rderr) begin
            err_sticky <= 1'b1;
            if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
`else
    logic unused_rderr;
    assign unused_rderr = fifo_rderr;
    assign err_sticky   = 1'b0;
    assign err_count    = '0;
`endif
endmodule

// File: tb/tb_fifo_drain_unpack.sv
// Bench for fifo_drain_unpack: instance A (36/4/1) for lane behaviour, instance B (36/1/2) for throughput.
// FIFO models pop on rd_en and return data after the read latency; the reference is the list of lanes of
// every word popped, dropped wholesale on flush or reset.
module tb_fifo_drain_unpack;
    localparam int W   = 36;
    localparam int LA  = 4;
    localparam int RLA = 1;
    localparam int LWA = W / LA;
    localparam int RLB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, flush_a, rderr_a;
    logic empty_a = 1'b1;
    logic rd_en_a;
    logic [W-1:0] dout_a = '0;
    logic err_sticky_a;
    logic [7:0] err_count_a;
    fifo_drain_unpack_if #(.LW(LWA)) ifa ();

    logic empty_b = 1'b1;
    logic rd_en_b;
    logic [W-1:0] dout_b = '0;
    logic [W-1:0] d1_b = '0;
    logic err_sticky_b;
    logic [7:0] err_count_b;
    fifo_drain_unpack_if #(.LW(W)) ifb ();

    fifo_drain_unpack #(.WIDTH(W), .LANES(LA), .RD_LAT(RLA)) dut_a (
        .clk(clk), .rstn(rstn), .flush(flush_a), .fifo_empty(empty_a), .fifo_dout(dout_a),
        .fifo_rderr(rderr_a), .fifo_rd_en(rd_en_a), .m(ifa),
        .err_sticky(err_sticky_a), .err_count(err_count_a)
    );

    fifo_drain_unpack #(.WIDTH(W), .LANES(1), .RD_LAT(RLB)) dut_b (
        .clk(clk), .rstn(rstn), .flush(1'b0), .fifo_empty(empty_b), .fifo_dout(dout_b),
        .fifo_rderr(1'b0), .fifo_rd_en(rd_en_b), .m(ifb),
        .err_sticky(err_sticky_b), .err_count(err_count_b)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0]  qa[$];
    logic [W-1:0]  qb[$];
    logic [11:0]   exp_a[$];     // {present, first, last, data}
    logic [23:0]   pairs_a[$];   // {received, expected}
    logic pop_a = 1'b0;
    logic pop_b = 1'b0;
    int rd_viol = 0;
    int cap_viol = 0;

    // FIFO models: pop at the edge ending a cycle with rd_en, data one (A) or two (B) cycles later.
    always @(posedge clk) begin
        if (pop_a && qa.size() > 0) begin
            dout_a <= qa[0];
            for (int l = 0; l < LA; l++)
                exp_a.push_back({1'b1, l == 0, l == LA - 1, qa[0][l*LWA +: LWA]});
            void'(qa.pop_front());
        end
        empty_a <= (qa.size() == 0);
        if (pop_b && qb.size() > 0) begin
            d1_b <= qb[0];
            void'(qb.pop_front());
        end
        dout_b  <= d1_b;
        empty_b <= (qb.size() == 0);
    end

    always @(negedge clk) begin
        logic [11:0] want;
        pop_a = rd_en_a;
        pop_b = rd_en_b;
        if ((rd_en_a && empty_a) || (rd_en_b && empty_b)) rd_viol++;
        if (!rstn || flush_a) begin
            exp_a.delete();
        end else if (ifa.m_valid && ifa.m_ready) begin
            want = 12'h0;
            if (exp_a.size() > 0) want = exp_a.pop_front();
            pairs_a.push_back({1'b1, ifa.m_first, ifa.m_last, ifa.m_data, want});
        end
        if (exp_a.size() > (RLA + 1) * LA) cap_viol++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        logic [23:0] p;
        int n;
        for (int i = 0; i < 3; i++) qa.push_back({4'($urandom), $urandom});
        step(3);
        checks++;
        if (ifa.m_valid !== 1'b0 || rd_en_a !== 1'b0) begin
            errors++; $display("FAIL reset_hold valid=%b rd_en=%b want 0 0", ifa.m_valid, rd_en_a);
        end
        checks++;
        if ({ifa.m_first, ifa.m_last} !== 2'b10 || ifa.m_data !== 9'h0) begin
            errors++; $display("FAIL reset_lane first/last=%b data=%h want 10 000", {ifa.m_first, ifa.m_last}, ifa.m_data);
        end
        checks++;
        if (err_count_a !== 8'h0 || err_sticky_a !== 1'b0) begin
            errors++; $display("FAIL reset_err count=%h sticky=%b want 00 0", err_count_a, err_sticky_a);
        end
        rstn = 1'b1;
        ifa.m_ready = 1'b1;
        step(4);
        checks++;
        if (ifa.m_valid !== 1'b1) begin
            errors++; $display("FAIL reset_run valid=%b want 1", ifa.m_valid);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (ifa.m_valid !== 1'b0 || rd_en_a !== 1'b0) begin
            errors++; $display("FAIL reset_async valid=%b rd_en=%b want 0 0", ifa.m_valid, rd_en_a);
        end
        step(2);
        rstn = 1'b1;
        n = 0;
        while ((qa.size() > 0 || exp_a.size() > 0 || ifa.m_valid) && n < 300) begin step(1); n++; end
        checks++;
        if (n >= 300) begin errors++; $display("FAIL reset_drain timeout cycles=%0d want <300", n); end
        checks++;
        if (pairs_a.size() !== 6) begin
            errors++; $display("FAIL reset_count lanes=%0d want 6", pairs_a.size());
        end
        while (pairs_a.size() > 0) begin
            p = pairs_a.pop_front();
            checks++;
            if (p[23:12] !== p[11:0]) begin errors++; $display("FAIL reset_lane_data got %h want %h", p[23:12], p[11:0]); end
        end
    endtask

    task automatic test_unpack;
        logic [8:0] lanes_exp [4];
        int n, lat;
        lanes_exp = '{9'h189, 9'h0B3, 9'h0D1, 9'h024};
        ifa.m_ready = 1'b1;
        qa.push_back(36'h1_2345_6789);
        n = 0;
        while (empty_a && n < 10) begin step(1); n++; end
        lat = 0;
        while (!ifa.m_valid && lat < 10) begin step(1); lat++; end
        checks++;
        if (lat !== RLA + 1) begin errors++; $display("FAIL unpack_latency got %0d want %0d", lat, RLA + 1); end
        for (int l = 0; l < LA; l++) begin
            checks++;
            if (ifa.m_valid !== 1'b1 || ifa.m_data !== lanes_exp[l] ||
                ifa.m_first !== (l == 0) || ifa.m_last !== (l == LA - 1)) begin
                errors++;
                $display("FAIL unpack_lane%0d valid=%b data=%h first=%b last=%b want 1 %h %b %b", l,
                         ifa.m_valid, ifa.m_data, ifa.m_first, ifa.m_last, lanes_exp[l], l == 0, l == LA - 1);
            end
            step(1);
        end
        checks++;
        if (ifa.m_valid !== 1'b0) begin errors++; $display("FAIL unpack_end valid=%b want 0", ifa.m_valid); end
        pairs_a.delete();
    endtask

    task automatic test_backpressure;
        logic [W-1:0] words [10];
        logic [8:0] hold;
        logic [23:0] p;
        int pulses, n;
        ifa.m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            words[i] = {4'($urandom), $urandom};
            qa.push_back(words[i]);
        end
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (rd_en_a) pulses++;
        end
        checks++;
        if (pulses !== RLA + 1) begin errors++; $display("FAIL bp_pulses got %0d want %0d", pulses, RLA + 1); end
        hold = ifa.m_data;
        step(5);
        checks++;
        if (ifa.m_valid !== 1'b1 || ifa.m_data !== hold || hold !== words[0][8:0]) begin
            errors++; $display("FAIL bp_stall valid=%b data=%h held=%h want 1 %h", ifa.m_valid, ifa.m_data, hold, words[0][8:0]);
        end
        ifa.m_ready = 1'b1;
        n = 0;
        while (pairs_a.size() < 40 && n < 300) begin step(1); n++; end
        step(3);
        checks++;
        if (pairs_a.size() !== 40) begin errors++; $display("FAIL bp_count lanes=%0d want 40", pairs_a.size()); end
        while (pairs_a.size() > 0) begin
            p = pairs_a.pop_front();
            checks++;
            if (p[23:12] !== p[11:0]) begin errors++; $display("FAIL bp_lane got %h want %h", p[23:12], p[11:0]); end
        end
    endtask

    task automatic test_throughput;
        logic [W-1:0] words [20];
        int n, lat;
        ifb.m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            words[i] = {4'($urandom), $urandom};
            qb.push_back(words[i]);
        end
        n = 0;
        while (empty_b && n < 10) begin step(1); n++; end
        lat = 0;
        while (!ifb.m_valid && lat < 10) begin step(1); lat++; end
        checks++;
        if (lat !== RLB + 1) begin errors++; $display("FAIL tput_latency got %0d want %0d", lat, RLB + 1); end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (ifb.m_valid !== 1'b1 || ifb.m_data !== words[i] || ifb.m_first !== 1'b1 || ifb.m_last !== 1'b1) begin
                errors++;
                $display("FAIL tput_word%0d valid=%b data=%h first=%b last=%b want 1 %h 1 1", i,
                         ifb.m_valid, ifb.m_data, ifb.m_first, ifb.m_last, words[i]);
            end
            step(1);
        end
        checks++;
        if (ifb.m_valid !== 1'b0) begin errors++; $display("FAIL tput_end valid=%b want 0", ifb.m_valid); end
    endtask

    task automatic test_flush;
        logic [W-1:0] w0, w1, w2;
        logic [23:0] p;
        int n;
        w0 = {4'($urandom), $urandom};
        w1 = {4'($urandom), $urandom};
        w2 = {4'($urandom), $urandom};
        ifa.m_ready = 1'b1;
        qa.push_back(w0);
        n = 0;
        while (!ifa.m_valid && n < 20) begin step(1); n++; end
        qa.push_back(w1);
        step(1);
        checks++;
        if (rd_en_a !== 1'b1 || ifa.m_data !== w0[17:9]) begin
            errors++; $display("FAIL flush_setup rd_en=%b data=%h want 1 %h", rd_en_a, ifa.m_data, w0[17:9]);
        end
        step(1);
        checks++;
        if (ifa.m_valid !== 1'b1 || ifa.m_data !== w0[26:18]) begin
            errors++; $display("FAIL flush_lane2 valid=%b data=%h want 1 %h", ifa.m_valid, ifa.m_data, w0[26:18]);
        end
        flush_a = 1'b1;
        qa.push_back(w2);
        step(1);
        flush_a = 1'b0;
        checks++;
        if (ifa.m_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", ifa.m_valid); end
        n = 0;
        while (!ifa.m_valid && n < 20) begin step(1); n++; end
        checks++;
        if (ifa.m_data !== w2[8:0] || ifa.m_first !== 1'b1) begin
            errors++; $display("FAIL flush_resume data=%h first=%b want %h 1", ifa.m_data, ifa.m_first, w2[8:0]);
        end
        n = 0;
        while ((qa.size() > 0 || exp_a.size() > 0 || ifa.m_valid) && n < 300) begin step(1); n++; end
        checks++;
        if (pairs_a.size() !== 6) begin errors++; $display("FAIL flush_count lanes=%0d want 6", pairs_a.size()); end
        while (pairs_a.size() > 0) begin
            p = pairs_a.pop_front();
            checks++;
            if (p[23:12] !== p[11:0]) begin errors++; $display("FAIL flush_lane got %h want %h", p[23:12], p[11:0]); end
        end
    endtask

    task automatic test_random;
        logic [23:0] p;
        int sent, n, got;
        sent = 0;
        for (int c = 0; c < 800; c++) begin
            if (sent < 40 && $urandom_range(3, 0) == 0) begin
                qa.push_back({4'($urandom), $urandom});
                sent++;
            end
            ifa.m_ready = ($urandom_range(9, 0) < 7);
            flush_a = ($urandom_range(49, 0) == 0);
            step(1);
        end
        flush_a = 1'b0;
        ifa.m_ready = 1'b1;
        n = 0;
        while ((qa.size() > 0 || exp_a.size() > 0 || ifa.m_valid) && n < 400) begin step(1); n++; end
        checks++;
        if (n >= 400) begin errors++; $display("FAIL rand_drain timeout cycles=%0d want <400", n); end
        got = pairs_a.size();
        checks++;
        if (got < 8) begin errors++; $display("FAIL rand_count lanes=%0d want >=8", got); end
        while (pairs_a.size() > 0) begin
            p = pairs_a.pop_front();
            checks++;
            if (p[23:12] !== p[11:0]) begin errors++; $display("FAIL rand_lane got %h want %h", p[23:12], p[11:0]); end
        end
        checks++;
        if (rd_viol !== 0 || cap_viol !== 0) begin
            errors++; $display("FAIL rand_bounds pop_on_empty=%0d over_capacity=%0d want 0 0", rd_viol, cap_viol);
        end
    endtask

    task automatic test_errors;
        logic [7:0] e5, eff, e1;
        logic es;
`ifdef FIFO_DRAIN_ERR_EN
        e5 = 8'd5; eff = 8'hFF; e1 = 8'd1; es = 1'b1;
`else
        e5 = 8'd0; eff = 8'h00; e1 = 8'd0; es = 1'b0;
`endif
        rderr_a = 1'b1;
        step(5);
        checks++;
        if (err_count_a !== e5 || err_sticky_a !== es) begin
            errors++; $display("FAIL err_count5 count=%h sticky=%b want %h %b", err_count_a, err_sticky_a, e5, es);
        end
        step(295);
        checks++;
        if (err_count_a !== eff || err_sticky_a !== es) begin
            errors++; $display("FAIL err_saturate count=%h sticky=%b want %h %b", err_count_a, err_sticky_a, eff, es);
        end
        flush_a = 1'b1;
        step(1);
        flush_a = 1'b0;
        checks++;
        if (err_count_a !== 8'h00 || err_sticky_a !== 1'b0) begin
            errors++; $display("FAIL err_flush count=%h sticky=%b want 00 0", err_count_a, err_sticky_a);
        end
        step(1);
        rderr_a = 1'b0;
        step(3);
        checks++;
        if (err_count_a !== e1 || err_sticky_a !== es) begin
            errors++; $display("FAIL err_after_flush count=%h sticky=%b want %h %b", err_count_a, err_sticky_a, e1, es);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        flush_a = 1'b0;
        rderr_a = 1'b0;
        ifa.m_ready = 1'b0;
        ifb.m_ready = 1'b0;
        test_reset();
        test_unpack();
        test_backpressure();
        test_throughput();
        test_flush();
        test_random();
        test_errors();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
